// File: rtl/adc_capture_trigger.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_trigger
//  Purpose  : Oscilloscope-style capture of an ADC sample stream. Fills a
//             pre-trigger history, waits for a level crossing and records
//             post-trigger samples into a ring buffer. The buffer is then
//             frozen for random-access readout.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_capture_trigger #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_sample_valid,
  input  logic              i_arm,
  input  logic [DATA_W-1:0] i_trig_level,
  input  logic              i_trig_rising,
  input  logic [ADDR_W-1:0] i_pretrig,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_armed,
  output logic              o_triggered,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic [ADDR_W-1:0] o_start_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_addr = '1;  // DEPTH-1

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              rising_q, rising_d;
  logic              prev_valid_q, prev_valid_d;
  logic              armed_q, armed_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q;

  logic              w_capturing;
  logic              w_wr_en;
  logic              w_trig_hit;

  logic [DATA_W-1:0] mem [DEPTH];

  // Any of the three capture states accepts samples into the ring.
  assign w_capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);

  // Level crossing between the previous and the current sample; needs a history sample.
  assign w_trig_hit = prev_valid_q &&
                      (rising_q ? ((prev_q < level_q) && (i_sample >= level_q))
                                : ((prev_q > level_q) && (i_sample <= level_q)));

  // Next-state, pointer/counter and status logic.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    pretrig_d    = pretrig_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    level_d      = level_q;
    prev_d       = prev_q;
    rising_d     = rising_q;
    prev_valid_d = prev_valid_q;
    w_wr_en      = 1'b0;

    if (i_arm) begin
      // The pretrig port is ADDR_W bits wide, so it can never exceed DEPTH-1
      // and the clamp is implicit.
      wr_ptr_d     = '0;
      cnt_d        = '0;
      pretrig_d    = i_pretrig;
      level_d      = i_trig_level;
      rising_d     = i_trig_rising;
      prev_valid_d = 1'b0;
      trig_addr_d  = '0;
      start_addr_d = '0;
      state_d      = (i_pretrig == '0) ? S_WAIT : S_PRE;
    end else if (!reset && i_sample_valid && w_capturing) begin
      w_wr_en      = 1'b1;
      wr_ptr_d     = wr_ptr_q + 1'b1;
      prev_d       = i_sample;
      prev_valid_d = 1'b1;
      case (state_q)
        S_PRE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == pretrig_q) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (w_trig_hit) begin
            trig_addr_d  = wr_ptr_q;
            start_addr_d = wr_ptr_q - pretrig_q;
            cnt_d        = c_last_addr - pretrig_q;
            state_d      = (cnt_d == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) state_d = S_DONE;
        end
        default: ;
      endcase
    end

    armed_d     = (state_d == S_PRE) || (state_d == S_WAIT);
    triggered_d = (state_d == S_POST) || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // State and control registers; reset wins over arm.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pretrig_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      level_q      <= '0;
      prev_q       <= '0;
      rising_q     <= 1'b0;
      prev_valid_q <= 1'b0;
      armed_q      <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      pretrig_q    <= pretrig_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      level_q      <= level_d;
      prev_q       <= prev_d;
      rising_q     <= rising_d;
      prev_valid_q <= prev_valid_d;
      armed_q      <= armed_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
    end
  end

  // Sample buffer write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) mem[wr_ptr_q] <= i_sample;
  end

  // Registered read port; a same-address write returns the old word.
  always_ff @(posedge i_clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem[i_rd_addr];
  end

  assign o_rd_data    = rd_data_q;
  assign o_armed      = armed_q;
  assign o_triggered  = triggered_q;
  assign o_done       = done_q;
  assign o_trig_addr  = trig_addr_q;
  assign o_start_addr = start_addr_q;

endmodule
`default_nettype wire

// File: doc/adc_capture_trigger.md
Name: adc_capture_trigger

Overview:
- Downstream consumer of the registered 8-bit AD9280 sample stream on J2, one sample per i_clk.
- Oscilloscope-style capture: arm, fill a pre-trigger history, wait for a level crossing, then record post-trigger samples into an inferred BRAM ring buffer.
- The capture is then frozen for random-access readout by a later display/UART stage.

Parameters:
- DATA_W, 8, sample width (AD9280 resolution).
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples.

Ports:
- i_clk  input  1  system clock (25 MHz), all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- i_sample  input  DATA_W  registered ADC sample.
- i_sample_valid  input  1  i_sample is valid this cycle; tie high for full rate.
- i_arm  input  1  single-cycle pulse that starts or restarts a capture.
- i_trig_level  input  DATA_W  unsigned trigger threshold, latched on arm.
- i_trig_rising  input  1  1 = rising edge, 0 = falling edge; latched on arm.
- i_pretrig  input  ADDR_W  number of samples kept before the trigger sample; latched on arm.
- i_rd_addr  input  ADDR_W  physical buffer read address.
- o_rd_data  output  DATA_W  buffer data, one cycle after i_rd_addr.
- o_armed  output  1  high in PRE and WAIT states.
- o_triggered  output  1  high in POST and DONE states.
- o_done  output  1  high in DONE state.
- o_trig_addr  output  ADDR_W  physical address holding the trigger sample.
- o_start_addr  output  ADDR_W  physical address of the oldest captured sample, equal to (o_trig_addr - pretrig) mod DEPTH.

Behaviour:
- Reset: state=IDLE. o_armed, o_triggered, o_done, o_trig_addr, o_start_addr and o_rd_data are all 0. wr_ptr=0. Buffer contents are not cleared.
- States: IDLE, PRE, WAIT, POST, DONE.
- i_arm in any state (reset low):
  - wr_ptr <= 0; counter <= 0.
  - Latch level, edge and pretrig. If i_pretrig > DEPTH-1, clamp it to DEPTH-1.
  - Clear prev_valid and the status outputs.
  - Next state is PRE, or WAIT if latched pretrig = 0.
  - A sample valid on the arm cycle is ignored.
- Write rule: in PRE, WAIT and POST, each cycle with i_sample_valid=1 writes i_sample at wr_ptr, then wr_ptr increments mod DEPTH. No write occurs in IDLE or DONE, or when i_sample_valid=0.
- PRE:
  - Count written samples.
  - On the write that makes count = pretrig, go to WAIT.
  - Trigger is not evaluated in PRE.
  - prev sample and prev_valid are updated on every write.
- WAIT:
  - Writes wrap continuously (ring).
  - Trigger condition on a valid sample s with prev_valid=1:
    - rising: prev < level && s >= level;
    - falling: prev > level && s <= level.
  - prev_valid=0 (the first sample after arm when pretrig=0) can never trigger.
  - On trigger:
    - s is written at wr_ptr;
    - o_trig_addr <= wr_ptr;
    - o_start_addr <= wr_ptr - pretrig (mod DEPTH);
    - post counter <= DEPTH-1-pretrig;
    - go to POST, or directly to DONE if that count is 0.
- POST: each valid write decrements the post counter; the write that reaches 0 moves to DONE.
- DONE: writes stop and status outputs hold until the next i_arm or reset.
- Total samples written from trigger through DONE = DEPTH - pretrig. Together with the pretrig history, the buffer holds exactly DEPTH contiguous samples starting at o_start_addr.
- Status outputs are registered and change the cycle after the state transition edge.
- Readout: synchronous read port with o_rd_data registered, latency 1 cycle. It is legal in any state. Reading during capture returns the current RAM contents; a same-address write/read collision returns the old data.
- Arithmetic: comparisons are unsigned DATA_W. All address arithmetic is mod DEPTH.
- Reset asserted mid-capture aborts to IDLE on that clock edge. Reset has priority over i_arm.

Test Plan (ADDR_W=4, DEPTH=16):
- Reset, then idle 5 cycles -> all outputs 0; no writes (buffer preloaded with 0xAA is unchanged).
- Arm with pretrig=4, level=0x80, rising; ramp 0x00,0x10,...,+0x10 every cycle -> trigger on sample 0x80 (the 9th sample, written at addr 8); o_trig_addr=8, o_start_addr=4; o_done is asserted after the 11 post samples. Reading 4..19 mod 16 returns 0x40..0x130 truncated to 8 bits, contiguous.
- Falling edge, level=0x40, pretrig=0, stream starts 0x30 then 0x50,0x40 -> no trigger on the first sample; trigger on 0x40; o_done after 15 further writes.
- i_sample_valid toggling 1,0,1,0 during PRE and POST -> only valid samples are written and counted; final buffer is identical to the full-rate run.
- i_pretrig=15 and a stream that never crosses the level -> o_armed stays high and wr_ptr wraps repeatedly. Re-arm mid-WAIT -> wr_ptr restarts at 0 and the status outputs clear.
- Reset asserted during POST -> IDLE next cycle with all outputs 0. Then arm together with reset high -> stays IDLE.
